// File: rtl/logic_unit_pipe.sv
// Purpose: two-stage pipelined bitwise logic unit (8 ops) with zero/parity/popcount flags.
// Latency: 2 cycles from accept to out_valid; sustains 1 beat/cycle with out_ready high.
// Backpressure: valid/ready on both sides; in_ready is combinational from out_ready, 2 beats buffered.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   in_valid/in_ready             operand stream handshake
//   in_a, in_b, in_op             operands and operation select
//                                 (000 AND, 001 OR, 010 XOR, 011 NOR,
//                                  100 NAND, 101 XNOR, 110 A&~B, 111 A)
//   out_valid/out_ready           result stream handshake
//   out_res, out_zero, out_par,
//   out_pop                       result, ==0 flag, XOR-reduction, count of ones
module logic_unit_pipe #(
  parameter int WIDTH = 32,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_par,
  output logic [CW-1:0]    out_pop
);

  // Stage 1: captured operands
  logic             v1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [2:0]       op1;

  // Stage 2 valid; stage 2 data lives directly in the out_* registers
  logic             v2;

  logic             adv2;
  logic             accept;
  logic [WIDTH-1:0] res1;
  logic [CW-1:0]    pop1;

  // S2 loads whenever S1 has a beat and S2 is empty or draining this cycle.
  assign adv2      = v1 & (~v2 | out_ready);
  // S1 can take a new beat if it is empty or handing its beat to S2.
  assign in_ready  = ~rst & (~v1 | adv2);
  assign accept    = in_valid & in_ready;
  assign out_valid = v2;

  always_comb begin
    res1 = '0;
    case (op1)
      3'b000:  res1 = a1 & b1;
      3'b001:  res1 = a1 | b1;
      3'b010:  res1 = a1 ^ b1;
      3'b011:  res1 = ~(a1 | b1);
      3'b100:  res1 = ~(a1 & b1);
      3'b101:  res1 = ~(a1 ^ b1);
      3'b110:  res1 = a1 & ~b1;
      default: res1 = a1;
    endcase
  end

  always_comb begin
    pop1 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop1 = pop1 + CW'(res1[i]);
    end
  end

  // Operand registers only load on an accepted beat, so garbage on the
  // inputs while in_valid is low never reaches state.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1  <= 1'b0;
      a1  <= '0;
      b1  <= '0;
      op1 <= '0;
    end else begin
      if (in_ready) begin
        v1 <= in_valid;
      end
      if (accept) begin
        a1  <= in_a;
        b1  <= in_b;
        op1 <= in_op;
      end
    end
  end

  // Outputs only change on adv2, so they hold while stalled (v2 & ~out_ready).
  always_ff @(posedge clk) begin
    if (rst) begin
      v2       <= 1'b0;
      out_res  <= '0;
      out_zero <= 1'b1;
      out_par  <= 1'b0;
      out_pop  <= '0;
    end else begin
      if (adv2) begin
        v2       <= 1'b1;
        out_res  <= res1;
        out_zero <= (res1 == '0);
        out_par  <= ^res1;
        out_pop  <= pop1;
      end else if (out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

endmodule
